// File: rtl/dx_skid_stage.sv
// dx_skid_stage: 2-entry skid FIFO with registered in_ready/out_valid.
// Optional saturating stall counter enabled by macro DX_SKID_STALL_CNT_EN.
module dx_skid_stage (
  input  logic        system1000,
  input  logic        system1000_rst,
  input  logic [55:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [55:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush
`ifdef DX_SKID_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state_q;
  logic [55:0] head_q;
  logic [55:0] tail_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        do_accept;
  logic        do_release;

  assign do_accept  = in_valid & in_ready_q;
  assign do_release = out_valid_q & out_ready;

  // FIFO state, storage and registered handshake outputs
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q     <= EMPTY;
      head_q      <= 56'd0;
      tail_q      <= 56'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= EMPTY;
      head_q      <= 56'd0;
      tail_q      <= 56'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (do_accept) begin
            head_q      <= in_data;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ONE: begin
          if (do_accept && !do_release) begin
            tail_q      <= in_data;
            state_q     <= FULL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (!do_accept && do_release) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end else if (do_accept && do_release) begin
            head_q      <= in_data;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end else begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only a release can happen
          if (do_release) begin
            head_q      <= tail_q;
            state_q     <= ONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end else begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

`ifdef DX_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled edges; flush does not clear it
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      stall_cnt_q <= 16'd0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dx_skid_stage.sv
// Self-checking bench for dx_skid_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_dx_skid_stage;

  logic        clk;
  logic        rst;
  logic [55:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
`ifdef DX_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int check_cnt;
  int error_cnt;

  logic [55:0] q_m[$];
  logic [55:0] od_m;
  bit          ir_m;
  int          cnt_m;

  localparam logic [55:0] A_V = 56'hFE03FFFF80FFFF;
  localparam logic [55:0] B_V = 56'h01020000808001;
  localparam logic [55:0] C_V = 56'h5A5A5A5A5A5A5A;
  localparam logic [55:0] D_V = 56'h123456789ABCDE;

  dx_skid_stage dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .flush         (flush)
`ifdef DX_SKID_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: advance the reference model, then compare all outputs
  task automatic tick();
    bit acc;
    bit rel;
    @(posedge clk);
    if (rst) begin
      q_m.delete();
      ir_m  = 1'b0;
      od_m  = 56'd0;
      cnt_m = 0;
    end else begin
      if (q_m.size() > 0 && !out_ready && cnt_m < 65535) cnt_m++;
      if (flush) begin
        q_m.delete();
        od_m = 56'd0;
        ir_m = 1'b1;
      end else begin
        acc = in_valid && ir_m;
        rel = (q_m.size() > 0) && out_ready;
        if (rel) void'(q_m.pop_front());
        if (acc) q_m.push_back(in_data);
        if (q_m.size() > 0) od_m = q_m[0];
        ir_m = (q_m.size() < 2);
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(q_m.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(ir_m));
    chk("out_data", 64'(out_data), 64'(od_m));
`ifdef DX_SKID_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
`endif
  endtask

  initial begin
    check_cnt = 0;
    error_cnt = 0;
    ir_m      = 1'b0;
    od_m      = 56'd0;
    cnt_m     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 56'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Stream of 1..5 with consumer always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 56'(i);
      tick();
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: fill with A, B then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A_V;
    tick();
    in_data = B_V;
    tick();
    in_valid = 1'b0;
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(out_data), 64'(A_V));
    tick();
    chk("bp_stable_a", 64'(out_data), 64'(A_V));
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", 64'(out_data), 64'(B_V));
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Simultaneous accept and release in ONE
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A_V;
    tick();
    in_data   = C_V;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("simul_head_c", 64'(out_data), 64'(C_V));
    chk("simul_one_ready", 64'(in_ready), 64'd1);
    tick();

    // Flush while FULL with a bundle offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A_V;
    tick();
    in_data = B_V;
    tick();
    flush   = 1'b1;
    in_data = D_V;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", 64'(out_data), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_d", 64'(out_valid), 64'd0);

    // Reset asserted while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = C_V;
    tick();
    in_data = D_V;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst_release", 64'(in_ready), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(3) != 0);
      flush     = 1'($urandom_range(24) == 0);
      rst       = 1'($urandom_range(99) == 0);
      in_data   = {24'($urandom), 32'($urandom)};
      tick();
    end
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;

`ifdef DX_SKID_STALL_CNT_EN
    // Long stall saturates the counter; flush leaves it alone
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A_V;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 70000; k++) tick();
    chk("stall_sat", 64'(stall_cnt), 64'd65535);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stall_after_flush", 64'(stall_cnt), 64'd65535);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
